// File: rtl/split_vec_driver.sv
// split_vec_driver
// Candidate generator for a combinational split constraint checker. A 32-bit
// Galois LFSR fills the packed vector one chunk per GEN cycle; the checker's
// verdict is sampled in CHECK. Accepted vectors are offered on a valid/ready
// solution port, rejected ones are regenerated until the retry budget is spent.
module split_vec_driver #(
    parameter int VEC_W     = 256,
    parameter int CHUNK_W   = 32,
    parameter int MAX_TRIES = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             start,
    output logic [VEC_W-1:0] vec_out,
    input  logic             chk_x,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [VEC_W-1:0] sol_data,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] try_count
);

    // Number of GEN cycles needed to cover the vector; last chunk may be partial.
    localparam int NCH = (VEC_W + CHUNK_W - 1) / CHUNK_W;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [KW-1:0]    K_LAST   = KW'(NCH - 1);
    localparam logic [KW-1:0]    K_ONE    = KW'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TRIES);
    localparam logic [31:0]      LFSR_RST = 32'h0000_0001;
    localparam logic [31:0]      LFSR_TAP = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) begin
            r = r ^ LFSR_TAP;
        end
        return r;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [31:0]        lfsr_r, lfsr_nxt_s;
    logic [VEC_W-1:0]   vec_r, vec_nxt_s;
    logic [KW-1:0]      k_r, k_nxt_s;
    logic [CNT_W-1:0]   try_r, try_nxt_s;
    logic               valid_r;
    logic               busy_r;
    logic               done_r, done_nxt_s;
    logic               fail_r, fail_nxt_s;

    // Next-state, LFSR, chunk fill and pulse generation.
    always_comb begin
        state_nxt_s = state_r;
        lfsr_nxt_s  = lfsr_r;
        vec_nxt_s   = vec_r;
        k_nxt_s     = k_r;
        try_nxt_s   = try_r;
        done_nxt_s  = 1'b0;
        fail_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A seed load wins over a simultaneous start.
                if (seed_load) begin
                    lfsr_nxt_s = (seed == 32'h0) ? LFSR_RST : seed;
                end else if (start) begin
                    state_nxt_s = ST_GEN;
                    try_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GEN: begin
                // The freshly advanced LFSR value lands in chunk k.
                lfsr_nxt_s = lfsr_step(lfsr_r);
                for (int b = 0; b < VEC_W; b++) begin
                    if ((b / CHUNK_W) == int'(k_r)) begin
                        vec_nxt_s[b] = lfsr_nxt_s[b % CHUNK_W];
                    end else begin
                        vec_nxt_s[b] = vec_r[b];
                    end
                end
                if (k_r == K_LAST) begin
                    k_nxt_s     = {KW{1'b0}};
                    state_nxt_s = ST_CHECK;
                end else begin
                    k_nxt_s = k_r + K_ONE;
                end
            end
            ST_CHECK: begin
                try_nxt_s = try_r + CNT_ONE;
                if (chk_x) begin
                    state_nxt_s = ST_OUT;
                end else if (try_nxt_s < CNT_MAX) begin
                    state_nxt_s = ST_GEN;
                end else begin
                    state_nxt_s = ST_IDLE;
                    fail_nxt_s  = 1'b1;
                end
            end
            ST_OUT: begin
                // Solution is held until the consumer takes it.
                if (sol_ready) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lfsr_r  <= LFSR_RST;
            vec_r   <= {VEC_W{1'b0}};
            k_r     <= {KW{1'b0}};
            try_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            lfsr_r  <= lfsr_nxt_s;
            vec_r   <= vec_nxt_s;
            k_r     <= k_nxt_s;
            try_r   <= try_nxt_s;
            valid_r <= (state_nxt_s == ST_OUT);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= done_nxt_s;
            fail_r  <= fail_nxt_s;
        end
    end

    assign vec_out   = vec_r;
    assign sol_data  = vec_r;
    assign sol_valid = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fail      = fail_r;
    assign try_count = try_r;

endmodule

// File: tb/tb_split_vec_driver.sv
// Self-checking bench for split_vec_driver: a run-level reference model tracks
// the expected outputs by elapsed cycles since start, and a negedge process
// compares the DUT against it every cycle.
module tb_split_vec_driver;

    localparam int VW  = 256;
    localparam int NCH = 8;
    localparam int MT  = 16;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          seed_load, start, chk_x, sol_ready;
    logic [31:0]   seed;
    logic [VW-1:0] vec_out, sol_data;
    logic          sol_valid, busy, done, fail;
    logic [CW-1:0] try_count;

    // Second instance exercising a truncated top chunk.
    logic          s_seed_load, s_start, s_chk, s_ready;
    logic [31:0]   s_seed;
    logic [39:0]   s_vec, s_data;
    logic          s_valid, s_busy, s_done, s_fail;
    logic [15:0]   s_try;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0]   m_lfsr    = 32'h1;
    logic [VW-1:0] exp_vec   = '0;
    bit            exp_busy  = 1'b0;
    bit            exp_valid = 1'b0;
    bit            exp_done  = 1'b0;
    bit            exp_fail  = 1'b0;
    int            exp_try   = 0;

    split_vec_driver #(.VEC_W(VW), .CHUNK_W(32), .MAX_TRIES(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
        .vec_out(vec_out), .chk_x(chk_x), .sol_valid(sol_valid), .sol_ready(sol_ready),
        .sol_data(sol_data), .busy(busy), .done(done), .fail(fail), .try_count(try_count)
    );

    split_vec_driver #(.VEC_W(40), .CHUNK_W(32), .MAX_TRIES(MT), .CNT_W(16)) dut_small (
        .clk(clk), .rst(rst), .seed_load(s_seed_load), .seed(s_seed), .start(s_start),
        .vec_out(s_vec), .chk_x(s_chk), .sol_valid(s_valid), .sol_ready(s_ready),
        .sol_data(s_data), .busy(s_busy), .done(s_done), .fail(s_fail), .try_count(s_try)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_step(input logic [31:0] x);
        return (x >> 1) ^ ((x % 2 == 1) ? 32'h80200003 : 32'h0);
    endfunction

    // Checker verdict policy per mode: 0 reject, 1 accept, 2 accept on try acc_at,
    // 3 accept when the candidate's low three bits are zero.
    function automatic bit verdict(input int mode, input int acc_at, input int try_no);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (try_no == acc_at);
            default: return (exp_vec[2:0] == 3'b000);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy", VW'(busy), VW'(exp_busy));
        chk("sol_valid", VW'(sol_valid), VW'(exp_valid));
        chk("done", VW'(done), VW'(exp_done));
        chk("fail", VW'(fail), VW'(exp_fail));
        chk("try_count", VW'(try_count), VW'(exp_try));
        chk("vec_out", vec_out, exp_vec);
        if (exp_valid) chk("sol_data", sol_data, exp_vec);
    end

    task automatic model_reset();
        m_lfsr = 32'h1; exp_vec = '0; exp_try = 0;
        exp_busy = 0; exp_valid = 0; exp_done = 0; exp_fail = 0;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        start = 0; seed_load = 0; sol_ready = 0; chk_x = 0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", VW'(busy), '0);
        chk("rst_valid", VW'(sol_valid), '0);
        chk("rst_try", VW'(try_count), '0);
        chk("rst_vec", vec_out, '0);
        chk("rst_pulses", VW'({done, fail}), '0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            seed_load = ($urandom_range(0, 2) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            start     = 1'b0;
            chk_x     = 1'($urandom);
            sol_ready = 1'($urandom);
            @(posedge clk); #1;
            exp_done = 0; exp_fail = 0;
            if (seed_load) m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
        end
        seed_load = 1'b0;
    endtask

    // One start..done/fail run; t_evt is the edge count (from the start edge)
    // at which the model saw the accept or the fail decision.
    task automatic run(input int mode, input int acc_at, input int rdy_pct,
                       input int hold, input int rst_at, output int t_evt);
        int t, p, n_out;
        bit fin, in_out, v, rdy_drv;
        t = 0; n_out = 0; fin = 0; in_out = 0; v = 0; t_evt = -1;
        start = 1'b1; seed_load = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1; exp_try = 0; exp_done = 0; exp_fail = 0;
        while (!fin) begin
            p = t % (NCH + 1);
            chk_x     = 1'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            seed_load = ($urandom_range(0, 3) == 0);
            seed      = $urandom;
            if (in_out) begin
                sol_ready = (n_out >= hold) && ($urandom_range(0, 99) < rdy_pct);
                n_out++;
            end else begin
                sol_ready = 1'($urandom);
                if (p == NCH) begin
                    v = verdict(mode, acc_at, exp_try + 1);
                    chk_x = v;
                end
            end
            rdy_drv = sol_ready;
            @(posedge clk); #1;
            t++;
            exp_done = 0; exp_fail = 0;
            if (rst_at != 0 && t == rst_at) begin
                do_reset();
                fin = 1;
            end else if (in_out) begin
                if (rdy_drv) begin
                    exp_done = 1; exp_valid = 0; exp_busy = 0; fin = 1;
                end
            end else if (p < NCH) begin
                m_lfsr = m_step(m_lfsr);
                for (int b = 0; b < 32; b++)
                    if (p * 32 + b < VW) exp_vec[p * 32 + b] = m_lfsr[b];
            end else begin
                exp_try++;
                if (v) begin
                    exp_valid = 1; in_out = 1; t_evt = t;
                end else if (exp_try >= MT) begin
                    exp_fail = 1; exp_busy = 0; fin = 1; t_evt = t;
                end
            end
            if (!fin && t > 800) begin
                total++; bad++;
                $display("FAIL run_timeout: got no completion after %0d cycles, want done or fail", t);
                fin = 1;
            end
        end
        start = 1'b0; seed_load = 1'b0; sol_ready = 1'b0;
    endtask

    initial begin
        int te;
        logic [31:0] v1, v2;
        logic [39:0] e40;
        rst = 1'b1;
        seed_load = 0; seed = '0; start = 0; chk_x = 0; sol_ready = 0;
        s_seed_load = 0; s_seed = '0; s_start = 0; s_chk = 1'b1; s_ready = 0;
        #1;
        chk("reset_vec", vec_out, '0);
        chk("reset_ctrl", VW'({busy, sol_valid, done, fail}), '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Seed 0 becomes 1; accept first candidate.
        seed_load = 1'b1; seed = 32'h0;
        @(posedge clk); #1;
        seed_load = 1'b0; m_lfsr = 32'h1;
        run(1, 0, 100, 0, 0, te);
        chk("t1_latency", VW'(te), VW'(9));
        chk("t1_chunk0", VW'(vec_out[31:0]), VW'(32'h80200003));
        chk("t1_chunk1", VW'(vec_out[63:32]), VW'(32'hC0300002));
        chk("t1_chunk2", VW'(vec_out[95:64]), VW'(32'h60180001));
        chk("t1_try", VW'(try_count), VW'(1));
        idle(3);

        // Always rejected: fail after MAX_TRIES rounds.
        run(0, 0, 100, 0, 0, te);
        chk("t2_fail_time", VW'(te), VW'(144));
        chk("t2_try", VW'(try_count), VW'(16));
        idle(2);

        // Accept on third check, consumer stalls five cycles.
        run(2, 3, 40, 5, 0, te);
        chk("t3_accept_time", VW'(te), VW'(27));
        chk("t3_try", VW'(try_count), VW'(3));
        idle(2);

        // seed_load and start together: seed taken, no run.
        seed_load = 1'b1; start = 1'b1; seed = 32'h12345678;
        @(posedge clk); #1;
        exp_done = 0; exp_fail = 0; m_lfsr = 32'h12345678;
        seed_load = 1'b0; start = 1'b0;
        chk("t4_still_idle", VW'(busy), '0);
        run(1, 0, 100, 0, 0, te);
        chk("t4_seeded_chunk0", VW'(vec_out[31:0]), VW'(m_step(32'h12345678)));

        // Reset in the middle of GEN, then a clean first-try run.
        run(1, 0, 100, 0, 4, te);
        run(1, 0, 100, 0, 0, te);
        chk("t5_latency", VW'(te), VW'(9));
        chk("t5_chunk0", VW'(vec_out[31:0]), VW'(32'h80200003));

        // Randomized runs.
        for (int i = 0; i < 30; i++) begin
            idle($urandom_range(1, 4));
            run($urandom_range(0, 3), $urandom_range(1, MT), $urandom_range(25, 100),
                $urandom_range(0, 3), 0, te);
        end
        idle(2);

        // Truncated top chunk: 40-bit vector, two GEN cycles.
        v1 = m_step(32'h1);
        v2 = m_step(v1);
        e40 = {v2[7:0], v1};
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_not_yet_valid", VW'({s_busy, s_valid}), VW'(2'b10));
        @(posedge clk); #1;
        chk("t6_valid", VW'(s_valid), VW'(1));
        chk("t6_vec", VW'(s_vec), VW'(e40));
        chk("t6_data", VW'(s_data), VW'(e40));
        chk("t6_try", VW'(s_try), VW'(1));
        s_ready = 1'b1;
        @(posedge clk); #1;
        s_ready = 1'b0;
        chk("t6_done", VW'({s_done, s_valid, s_busy, s_fail}), VW'(4'b1000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
